// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the PPU instruction-fetch queue.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCH_QUEUE_BYPASS_EN.
package fetch_queue_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  // Canonical no-op encoding used by the pipeline when it needs to inject a bubble.
  localparam logic [INSTR_W-1:0] FQ_NOP = 32'h0100_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fq_entry_t;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue signal bundle: redirect, instruction-memory handshake and decode-side handshake.
// master = the fetch queue itself, slave = the surrounding memory/decode environment.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [PC_W-1:0]    out_npc;
  logic               out_ready;

  modport master (
    input  redirect, redirect_pc,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  out_ready,
    output imem_req, imem_addr,
    output out_valid, out_instr, out_pc, out_npc
  );

  modport slave (
    output redirect, redirect_pc,
    output imem_gnt, imem_rvalid, imem_rdata,
    output out_ready,
    input  imem_req, imem_addr,
    input  out_valid, out_instr, out_pc, out_npc
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Power-of-two circular FIFO with occupancy count and synchronous clear.
// Used both for buffered {instr, pc} entries and for the in-flight PC tags.
module fetch_queue_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: storage is deliberately left out of reset; count qualifies every read,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential address generation, credit-limited issue,
// in-order response buffering and redirect flush. FETCH_QUEUE_BYPASS_EN adds empty-queue bypass.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master fq
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] tag_head;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic            issue;
  logic            resp;
  logic            drop;
  logic            accept;
  logic            push;
  logic            pop;
  fq_entry_t       head;
  fq_entry_t       wentry;

  // Buffered plus in-flight fetches never exceed DEPTH, so a response always has a slot.
  assign fq.imem_req  = !reset && !fq.redirect &&
                        (({1'b0, count} + {1'b0, outstanding}) < DEPTH_C);
  assign fq.imem_addr = fetch_pc;
  assign issue        = fq.imem_req && fq.imem_gnt;

  // A response with nothing in flight is stale (e.g. crossed a reset) and is ignored.
  assign resp   = fq.imem_rvalid && (outstanding != '0);
  assign drop   = resp && (discard != '0);
  assign accept = resp && !drop && !fq.redirect;
  assign pop    = (count != '0) && fq.out_ready && !fq.redirect;
  assign wentry = '{instr: fq.imem_rdata, pc: tag_head};

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass = resp && !drop && (count == '0);
  // A bypassed word taken by decode the same cycle never occupies a slot.
  assign push   = accept && !(bypass && fq.out_ready);
`else
  assign push   = accept;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (fq.redirect) begin
      fetch_pc <= fq.redirect_pc;
    end else if (issue) begin
      fetch_pc <= next_pc(fetch_pc);
    end
  end

  // Everything still in flight after a redirect belongs to the old path; issue is gated
  // during redirect, so only this cycle's response reduces the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      discard <= '0;
    end else if (fq.redirect) begin
      discard <= outstanding - CW'(resp);
    end else if (drop) begin
      discard <= discard - 1'b1;
    end
  end

  // PC tags of issued requests; responses return in order, so the head tags the next word.
  fetch_queue_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .push  (issue),
    .wdata (fetch_pc),
    .pop   (resp),
    .rdata (tag_head),
    .count (outstanding)
  );

  fetch_queue_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fq_entry_t))
  ) u_data_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (fq.redirect),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    fq.out_valid = 1'b0;
    fq.out_instr = '0;
    fq.out_pc    = '0;
    if (count != '0) begin
      fq.out_valid = 1'b1;
      fq.out_instr = head.instr;
      fq.out_pc    = head.pc;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (bypass) begin
      fq.out_valid = 1'b1;
      fq.out_instr = fq.imem_rdata;
      fq.out_pc    = tag_head;
    end
`endif
  end

  assign fq.out_npc = next_pc(fq.out_pc);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory model returning addr as data one cycle
// after grant; FETCH_QUEUE_BYPASS_EN selects the expected same-cycle behaviour.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if fq();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          issued = 0;
  logic        resp_en;
  logic        spurious;
  logic [31:0] pend[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  logic [31:0] got_npc[$];
  int          got_cyc[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic clear_got();
    got_pc.delete();
    got_instr.delete();
    got_npc.delete();
    got_cyc.delete();
  endtask

  task automatic drive_mem();
    if (spurious) begin
      fq.imem_rvalid = 1'b1;
      fq.imem_rdata  = 32'hdead_beef;
    end else if (resp_en && pend.size() != 0) begin
      fq.imem_rvalid = 1'b1;
      fq.imem_rdata  = pend[0];
    end else begin
      fq.imem_rvalid = 1'b0;
      fq.imem_rdata  = '0;
    end
  endtask

  // One clock: drive memory, sample handshakes mid-cycle, advance, update the memory model.
  task automatic cycle();
    logic        hs;
    logic        rv;
    logic [31:0] a;
    drive_mem();
    #1;
    hs = fq.imem_req && fq.imem_gnt;
    a  = fq.imem_addr;
    rv = fq.imem_rvalid && !spurious;
    if (fq.out_valid && fq.out_ready && !fq.redirect && !reset) begin
      got_pc.push_back(fq.out_pc);
      got_instr.push_back(fq.out_instr);
      got_npc.push_back(fq.out_npc);
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      pend.delete();
    end else begin
      if (rv && pend.size() != 0) void'(pend.pop_front());
      if (hs) begin
        pend.push_back(a);
        issued++;
      end
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    fq.redirect = 1'b0;
    spurious    = 1'b0;
    pend.delete();
    clear_got();
    issued = 0;
    drive_mem();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    int k = 0;
    while (got_pc.size() < n && k < budget) begin
      cycle();
      k++;
    end
    if (got_pc.size() < n) check({tag, "_timeout"}, got_pc.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fq.redirect    = 1'b0;
    fq.redirect_pc = '0;
    fq.imem_gnt    = 1'b0;
    fq.imem_rvalid = 1'b0;
    fq.imem_rdata  = '0;
    fq.out_ready   = 1'b0;
    resp_en        = 1'b0;
    spurious       = 1'b0;

    // Reset state
    reset = 1'b1;
    #1;
    check("rst_valid", fq.out_valid, 0);
    check("rst_instr", fq.out_instr, 0);
    check("rst_pc",    fq.out_pc,    0);
    check("rst_npc",   fq.out_npc,   4);
    check("rst_req",   fq.imem_req,  0);

    // 1: streaming, one entry per cycle
    do_reset();
    fq.imem_gnt = 1'b1; resp_en = 1'b1; fq.out_ready = 1'b1;
    wait_pops(4, 20, "t1");
    for (int i = 0; i < 4; i++) begin
      check("t1_pc",    got_pc[i],    32'(4 * i));
      check("t1_instr", got_instr[i], 32'(4 * i));
      check("t1_npc",   got_npc[i],   32'(4 * i + 4));
    end
    for (int i = 1; i < 4; i++) check("t1_consec", 32'(got_cyc[i] - got_cyc[i-1]), 1);

    // 2: stall fills credits, then drains in order
    do_reset();
    fq.imem_gnt = 1'b1; resp_en = 1'b1; fq.out_ready = 1'b0;
    repeat (10) cycle();
    check("t2_issued", issued, DEPTH);
    check("t2_req_low", fq.imem_req, 0);
    fq.out_ready = 1'b1;
    wait_pops(5, 20, "t2");
    for (int i = 0; i < 5; i++) check("t2_pc", got_pc[i], 32'(4 * i));

    // 3: redirect with two requests in flight
    do_reset();
    fq.imem_gnt = 1'b1; resp_en = 1'b0; fq.out_ready = 1'b1;
    cycle();
    cycle();
    fq.imem_gnt    = 1'b0;
    fq.redirect    = 1'b1;
    fq.redirect_pc = 32'h100;
    #1;
    check("t3_req_gated", fq.imem_req, 0);
    cycle();
    clear_got();
    fq.redirect = 1'b0; fq.imem_gnt = 1'b1; resp_en = 1'b1;
    check("t3_addr", fq.imem_addr, 32'h100);
    wait_pops(2, 20, "t3");
    check("t3_pc0",    got_pc[0],    32'h100);
    check("t3_instr0", got_instr[0], 32'h100);
    check("t3_pc1",    got_pc[1],    32'h104);
    check("t3_npc1",   got_npc[1],   32'h108);

    // 4: grant withheld keeps the address stable
    do_reset();
    fq.imem_gnt = 1'b0; resp_en = 1'b1; fq.out_ready = 1'b1;
    repeat (3) begin
      cycle();
      check("t4_req",  fq.imem_req,  1);
      check("t4_addr", fq.imem_addr, 0);
    end
    fq.imem_gnt = 1'b1;
    cycle();
    check("t4_addr_adv", fq.imem_addr, 4);

    // 5: credits exhausted, then pop and response on the same edge
    do_reset();
    fq.imem_gnt = 1'b1; resp_en = 1'b1; fq.out_ready = 1'b0;
    repeat (4) cycle();
    check("t5_req_credit", fq.imem_req, 0);
    check("t5_head0", fq.out_pc, 0);
    fq.out_ready = 1'b1;
    cycle();
    check("t5_head1", fq.out_pc, 4);
    check("t5_req_again", fq.imem_req, 1);
    check("t5_addr", fq.imem_addr, 16);
    wait_pops(6, 20, "t5");
    for (int i = 0; i < 6; i++) check("t5_pc", got_pc[i], 32'(4 * i));

    // 6: reset mid-operation, stale response, restart at RESET_PC
    do_reset();
    fq.imem_gnt = 1'b1; resp_en = 1'b1; fq.out_ready = 1'b0;
    repeat (4) cycle();
    check("t6_pre_valid", fq.out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", fq.out_valid, 0);
    check("t6_async_req",   fq.imem_req,  0);
    @(posedge clk);
    #1;
    pend.delete();
    reset = 1'b0;
    clear_got();
    fq.imem_gnt = 1'b0; fq.out_ready = 1'b1; spurious = 1'b1;
    cycle();
    spurious = 1'b0;
    check("t6_stale_ignored", fq.out_valid, 0);
    fq.imem_gnt = 1'b1;
    cycle();
    drive_mem();
    #1;
    check("t6_same_cycle_valid", fq.out_valid, BYP);
    check("t6_same_cycle_pc", fq.out_pc, 0);
    wait_pops(2, 20, "t6");
    check("t6_first_pc", got_pc[0], 32'h0);
    check("t6_second_pc", got_pc[1], 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
